// File: rtl/alu_op_sequencer.sv
// Parses 0xCC/0xDD ALU command frames from UART RX, issues the ALU operation
// and returns the 16-bit result LSB-first over the UART TX handshake.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic                  TX_BUSY,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  output logic                  CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  ERR
);

  localparam logic [DATA_WIDTH-1:0] CMD_LOAD  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);
  localparam logic [7:0]            TO_LAST   = 8'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, GATE, ISSUE, WAIT_RES,
    SEND_LO, ACK_LO, SEND_HI, ACK_HI
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [OUT_WIDTH-1:0]   res, res_nxt;
  logic [3:0]             fun_nxt;
  logic [DATA_WIDTH-1:0]  op_a_nxt, op_b_nxt, tx_dat_nxt;
  logic                   en_nxt, gate_nxt, tx_vld_nxt, err_nxt;
  logic                   fun_bad;

  assign fun_bad = |RX_P_DATA[DATA_WIDTH-1:4];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_D_VLD && RX_P_DATA == CMD_LOAD)       state_nxt = GET_A;
        else if (RX_D_VLD && RX_P_DATA == CMD_REUSE) state_nxt = GET_FUN;
      end
      GET_A:    if (RX_D_VLD) state_nxt = GET_B;
      GET_B:    if (RX_D_VLD) state_nxt = GET_FUN;
      GET_FUN:  if (RX_D_VLD) state_nxt = fun_bad ? IDLE : GATE;
      GATE:     state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_RES;
      WAIT_RES: begin
        // a result arriving on the terminal count still wins over the timeout
        if (ALU_OUT_VALID)       state_nxt = SEND_LO;
        else if (cnt == TO_LAST) state_nxt = IDLE;
      end
      SEND_LO:  if (!TX_BUSY) state_nxt = ACK_LO;
      ACK_LO:   if (TX_BUSY)  state_nxt = SEND_HI;
      SEND_HI:  if (!TX_BUSY) state_nxt = ACK_HI;
      ACK_HI:   if (TX_BUSY)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_a_nxt   = OP_A;
    op_b_nxt   = OP_B;
    fun_nxt    = ALU_FUN;
    res_nxt    = res;
    tx_dat_nxt = TX_P_DATA;
    cnt_nxt    = (state == WAIT_RES) ? cnt + 8'd1 : 8'd0;
    en_nxt     = (state_nxt == ISSUE);
    gate_nxt   = (state_nxt == GATE) || (state_nxt == ISSUE) || (state_nxt == WAIT_RES);
    tx_vld_nxt = ((state == SEND_LO) || (state == SEND_HI)) && !TX_BUSY;
    err_nxt    = ((state == GET_FUN) && RX_D_VLD && fun_bad) ||
                 ((state == WAIT_RES) && !ALU_OUT_VALID && cnt == TO_LAST);
    if (state == GET_A && RX_D_VLD) op_a_nxt = RX_P_DATA;
    if (state == GET_B && RX_D_VLD) op_b_nxt = RX_P_DATA;
    if (state == GET_FUN && RX_D_VLD && !fun_bad) fun_nxt = RX_P_DATA[3:0];
    if (state == WAIT_RES && ALU_OUT_VALID) res_nxt = ALU_OUT;
    if (state == SEND_LO && !TX_BUSY) tx_dat_nxt = res[DATA_WIDTH-1:0];
    if (state == SEND_HI && !TX_BUSY) tx_dat_nxt = res[OUT_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OP_A        <= '0;
      OP_B        <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      ERR         <= 1'b0;
      res         <= '0;
      cnt         <= '0;
    end else begin
      OP_A        <= op_a_nxt;
      OP_B        <= op_b_nxt;
      ALU_FUN     <= fun_nxt;
      ALU_EN      <= en_nxt;
      CLK_GATE_EN <= gate_nxt;
      TX_P_DATA   <= tx_dat_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      ERR         <= err_nxt;
      res         <= res_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side counterpart to the ALU function decoder. It parses ALU command frames arriving byte-wise from the UART receive path and registers operands A and B. It then encodes and issues `ALU_FUN` with a one-cycle `ALU_EN`, gating the ALU clock only while an operation is in flight. It captures the 16-bit result and returns it LSB-first over the UART transmit handshake.

## Interface
- `DATA_WIDTH`, 8, width of operands and of RX/TX bytes.
- `OUT_WIDTH`, 16, width of the ALU result; must equal 2×`DATA_WIDTH`.
- `TIMEOUT`, 15, maximum cycles in WAIT_RES before error; range 1..255.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: asynchronous, active-high reset.
- `RX_P_DATA` in `DATA_WIDTH`: received byte.
- `RX_D_VLD` in 1: one-cycle strobe, byte valid.
- `ALU_OUT` in `OUT_WIDTH`: ALU result.
- `ALU_OUT_VALID` in 1: result valid strobe.
- `TX_BUSY` in 1: transmitter busy.
- `ALU_FUN` out 4: encoded ALU function. Bits [3:2] select the arithmetic, logic, compare or shift unit.
- `ALU_EN` out 1: one-cycle operation start.
- `OP_A`, `OP_B` out `DATA_WIDTH`: registered operands.
- `CLK_GATE_EN` out 1: ALU clock-gate enable.
- `TX_P_DATA` out `DATA_WIDTH`: byte to transmit.
- `TX_D_VLD` out 1: one-cycle transmit strobe.
- `ERR` out 1: one-cycle error pulse.

## Operation
- All outputs are registered.
- Reset values: every output is 0, and the state is IDLE.
- Frame formats:
  - 0xCC, A, B, FUN: load new operands, then execute.
  - 0xDD, FUN: execute with the held OP_A/OP_B.
- States: IDLE, GET_A, GET_B, GET_FUN, GATE, ISSUE, WAIT_RES, SEND_LO, ACK_LO, SEND_HI, ACK_HI.
- IDLE transitions on `RX_D_VLD`:
  - 0xCC → GET_A.
  - 0xDD → GET_FUN.
  - Any other byte is silently ignored.
- GET_A, GET_B: on `RX_D_VLD`, capture the byte into `OP_A` / `OP_B` and advance. Operands persist across frames.
- GET_FUN: on `RX_D_VLD`:
  - If byte[7:4] ≠ 0: pulse `ERR`, go to IDLE, leave `ALU_FUN` unchanged.
  - Otherwise: register `ALU_FUN` = byte[3:0] and go to GATE.
- GATE: `CLK_GATE_EN` = 1; next state is ISSUE.
- ISSUE: `ALU_EN` = 1 for exactly this cycle; next state is WAIT_RES.
- WAIT_RES: a counter starts at 0 and increments each cycle.
  - `ALU_OUT_VALID` = 1: capture `ALU_OUT` into the result register and go to SEND_LO.
  - Counter reaches `TIMEOUT` with no valid: pulse `ERR`, go to IDLE.
- `CLK_GATE_EN` = 1 exactly while the state is GATE, ISSUE or WAIT_RES.
- `ALU_FUN` is held from GATE until the next accepted FUN byte.
- SEND_LO: wait while `TX_BUSY` = 1. When `TX_BUSY` = 0, drive `TX_P_DATA` = result[7:0] and `TX_D_VLD` = 1 for one cycle, then go to ACK_LO.
- ACK_LO: wait for `TX_BUSY` = 1, then go to SEND_HI.
- SEND_HI and ACK_HI behave like SEND_LO and ACK_LO, using result[15:8]. From ACK_HI, `TX_BUSY` = 1 → IDLE.
- `TX_P_DATA` holds its last value between strobes.
- `RX_D_VLD` in any state from GATE through ACK_HI is dropped, with no error.
- `ALU_OUT_VALID` outside WAIT_RES is ignored.
- `RST` mid-frame or mid-operation aborts everything immediately: outputs return to reset values, including `OP_A`/`OP_B`.

## Timing
- Byte accepted at edge k → the state or register update is visible after edge k.
- FUN accepted at edge N:
  - `CLK_GATE_EN` rises in cycle N+1, one cycle ahead of `ALU_EN`.
  - `ALU_EN` is high in cycle N+2.
  - WAIT_RES starts in cycle N+3.
- `ALU_OUT_VALID` sampled at edge M in WAIT_RES:
  - `CLK_GATE_EN` falls in cycle M+1.
  - With `TX_BUSY` low, `TX_D_VLD` (LSB) pulses in cycle M+2.
- Minimum FUN-to-first-TX latency is 5 cycles when the ALU returns valid in the first WAIT_RES cycle.
- Timeout: `ERR` pulses in the cycle after the counter's terminal cycle, and `CLK_GATE_EN` drops in that same cycle.
- `TX_D_VLD` is never asserted while `TX_BUSY` = 1 is sampled on the same edge.

## Test plan
- Full frame: RX 0xCC, 0x05, 0x03, 0x00; ALU returns 0x0008 two cycles after `ALU_EN`.
  - Expect `OP_A`=5, `OP_B`=3, `ALU_FUN`=0x0, one `ALU_EN` pulse.
  - Expect TX bytes 0x08 then 0x00, each after `TX_BUSY` low.
  - Expect `CLK_GATE_EN` high for exactly GATE..WAIT_RES.
- Reuse frame: after the first test, RX 0xDD, 0x0A.
  - Expect `OP_A`/`OP_B` unchanged and `ALU_FUN`=0xA.
  - Feed a result of 0x1234 → TX 0x34, 0x12.
- Illegal FUN: RX 0xDD, 0x3F → one `ERR` pulse, no `ALU_EN`, no `CLK_GATE_EN`, `ALU_FUN` unchanged.
- Timeout: `TIMEOUT`=4 and `ALU_OUT_VALID` held low → `ERR` pulses 5 cycles after WAIT_RES entry, state returns to IDLE, no TX strobe.
- TX backpressure, with `TX_BUSY` held high for 10 cycles on entering SEND_LO:
  - `TX_D_VLD` fires on the first low cycle.
  - RX bytes injected during sending are dropped, and the next 0xCC frame then works normally.
- Reset mid-operation: assert `RST` asynchronously during WAIT_RES → all outputs are 0 immediately, and a subsequent valid frame completes correctly.
